// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the tower-defence game datapath: map geometry,
// sprite size, 30 fps frame period at 50 MHz and the tower state encoding.
// No ports; imported by the game modules.
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int MAP_W            = 160;
    localparam int MAP_H            = 120;
    localparam int SPRITE_SIZE      = 20;
    localparam int SPRITE_HALF      = SPRITE_SIZE / 2;
    localparam int FRAME_CLKS_30FPS = 1666666;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_FIRE      = 3'd2,
        ST_COOLDOWN  = 3'd3,
        ST_DESTROYED = 3'd4
    } tower_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// ---------------------------------------------------------------------------
// frame_tick_gen
// Free-running counter 0..FRAME_CLKS-1 producing a one-cycle registered pulse
// each time the counter wraps.
// Ports:
//   clk    in  system clock
//   resetn in  asynchronous active-low reset
//   tick   out one-cycle pulse per FRAME_CLKS clocks
// ---------------------------------------------------------------------------
module frame_tick_gen
    import game_pkg::*;
#(
    parameter int FRAME_CLKS = FRAME_CLKS_30FPS
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int              CNT_W = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CLKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == LAST);
        cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/tower_targeting.sv
// ---------------------------------------------------------------------------
// tower_targeting
// One fixed tower: checks whether the car sprite centre lies inside a square
// attack zone, fires once per frame tick when armed, counts down the car's
// hit points and raises a destroyed level for the car controller.
// Ports:
//   clk           in  system clock (50 MHz)
//   resetn        in  asynchronous active-low reset
//   enable        in  game running; low pauses the tower
//   car_reset     in  new wave / car restart; reloads hit points
//   car_active    in  car is on the path
//   car_x         in  car top-left x on map (8 bits)
//   car_y         in  car top-left y on map (7 bits)
//   in_range      out registered range result
//   fire          out one-cycle shot pulse
//   car_hp        out remaining hit points
//   car_destroyed out held high until car_reset
//   frame_tick    out one-cycle pulse per frame
// ---------------------------------------------------------------------------
module tower_targeting
    import game_pkg::*;
#(
    parameter int TOWER_X         = 60,
    parameter int TOWER_Y         = 40,
    parameter int RANGE           = 30,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int CAR_HP          = 5,
    parameter int FRAME_CLKS      = FRAME_CLKS_30FPS
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       car_reset,
    input  logic       car_active,
    input  logic [7:0] car_x,
    input  logic [6:0] car_y,
    output logic       in_range,
    output logic       fire,
    output logic [3:0] car_hp,
    output logic       car_destroyed,
    output logic       frame_tick
);

    localparam logic signed [9:0] TX      = 10'(TOWER_X);
    localparam logic signed [9:0] TY      = 10'(TOWER_Y);
    localparam logic        [9:0] RNG     = 10'(RANGE);
    localparam logic        [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);
    localparam logic        [3:0] HP_INIT = 4'(CAR_HP);

    function automatic logic [9:0] abs10(input logic signed [9:0] v);
        return (v < 0) ? 10'(-v) : 10'(v);
    endfunction

    logic              tick_w;
    logic        [8:0] cx, cy;
    logic signed [9:0] dx, dy;
    logic              in_range_d, in_range_q;
    tower_state_t      state_q, state_d;
    logic        [7:0] cd_q, cd_d;
    logic        [3:0] hp_q, hp_d;

    frame_tick_gen #(
        .FRAME_CLKS(FRAME_CLKS)
    ) u_frame_tick (
        .clk   (clk),
        .resetn(resetn),
        .tick  (tick_w)
    );

    // Centre is widened to 9 bits and the difference to 10-bit signed so the
    // distance never wraps, even for car positions off the visible map.
    always_comb begin
        cx         = {1'b0, car_x} + 9'(SPRITE_HALF);
        cy         = {2'b00, car_y} + 9'(SPRITE_HALF);
        dx         = $signed({1'b0, cx}) - TX;
        dy         = $signed({1'b0, cy}) - TY;
        in_range_d = (abs10(dx) <= RNG) && (abs10(dy) <= RNG);
    end

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        hp_d    = hp_q;
        if (car_reset) begin
            state_d = ST_IDLE;
            hp_d    = HP_INIT;
            cd_d    = '0;
        end else if (!enable) begin
            // Pause keeps hit points and cooldown; a destroyed car stays
            // destroyed until it is explicitly restarted.
            if (state_q != ST_DESTROYED) begin
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (car_active) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!car_active) begin
                        state_d = ST_IDLE;
                    end else if (in_range_q && tick_w) begin
                        state_d = ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    hp_d = (hp_q != 4'd0) ? hp_q - 4'd1 : 4'd0;
                    if (hp_q <= 4'd1) begin
                        state_d = ST_DESTROYED;
                    end else begin
                        cd_d    = CD_LOAD;
                        state_d = ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    // Leaving only on a tick-free cycle means the next shot
                    // always waits for a fresh frame tick.
                    if (!car_active) begin
                        state_d = ST_IDLE;
                    end else if (tick_w) begin
                        if (cd_q != 8'd0) cd_d = cd_q - 8'd1;
                    end else if (cd_q == 8'd0) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_DESTROYED: begin
                    state_d = ST_DESTROYED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cd_q       <= '0;
            hp_q       <= HP_INIT;
            in_range_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cd_q       <= cd_d;
            hp_q       <= hp_d;
            in_range_q <= in_range_d;
        end
    end

    assign in_range      = in_range_q;
    assign fire          = (state_q == ST_FIRE);
    assign car_destroyed = (state_q == ST_DESTROYED);
    assign car_hp        = hp_q;
    assign frame_tick    = tick_w;

endmodule

// File: tb/tb_tower_targeting.sv
module tb_tower_targeting;

    localparam int FR  = 4;
    localparam int CDF = 2;
    localparam int HP0 = 3;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b0;
    logic       enable     = 1'b0;
    logic       car_reset  = 1'b0;
    logic       car_active = 1'b0;
    logic [7:0] car_x      = 8'd0;
    logic [6:0] car_y      = 7'd0;
    logic       in_range, fire, car_destroyed, frame_tick;
    logic [3:0] car_hp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    tower_targeting #(
        .TOWER_X(60), .TOWER_Y(40), .RANGE(30),
        .COOLDOWN_FRAMES(CDF), .CAR_HP(HP0), .FRAME_CLKS(FR)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .car_reset(car_reset),
        .car_active(car_active), .car_x(car_x), .car_y(car_y),
        .in_range(in_range), .fire(fire), .car_hp(car_hp),
        .car_destroyed(car_destroyed), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_FIRE = 2, M_COOL = 3, M_DEAD = 4;

    int m_st  = M_IDLE;
    int m_hp  = HP0;
    int m_cd  = 0;
    int m_cnt = 0;
    bit m_tick = 0;
    bit m_inr  = 0;
    bit m_t, m_r;

    function automatic bit near(input int x, input int y);
        int ax = x + 10 - 60;
        int ay = y + 10 - 40;
        if (ax < 0) ax = -ax;
        if (ay < 0) ay = -ay;
        return (ax <= 30) && (ay <= 30);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_st = M_IDLE; m_hp = HP0; m_cd = 0; m_cnt = 0; m_tick = 0; m_inr = 0;
        end else begin
            m_t = m_tick;
            m_r = m_inr;
            m_tick = (m_cnt == FR - 1);
            m_cnt  = (m_cnt + 1) % FR;
            m_inr  = near(int'(car_x), int'(car_y));
            if (car_reset) begin
                m_st = M_IDLE; m_hp = HP0; m_cd = 0;
            end else if (!enable) begin
                if (m_st != M_DEAD) m_st = M_IDLE;
            end else begin
                case (m_st)
                    M_IDLE:  if (car_active) m_st = M_ARMED;
                    M_ARMED: begin
                        if (!car_active) m_st = M_IDLE;
                        else if (m_r && m_t) m_st = M_FIRE;
                    end
                    M_FIRE: begin
                        if (m_hp <= 1) begin
                            m_hp = 0; m_st = M_DEAD;
                        end else begin
                            m_hp = m_hp - 1; m_cd = CDF; m_st = M_COOL;
                        end
                    end
                    M_COOL: begin
                        if (!car_active) m_st = M_IDLE;
                        else if (m_t) begin
                            if (m_cd > 0) m_cd = m_cd - 1;
                        end else if (m_cd == 0) m_st = M_ARMED;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("in_range", int'(in_range), int'(m_inr));
            cmp("frame_tick", int'(frame_tick), int'(m_tick));
            cmp("fire", int'(fire), int'(m_st == M_FIRE));
            cmp("car_hp", int'(car_hp), m_hp);
            cmp("car_destroyed", int'(car_destroyed), int'(m_st == M_DEAD));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_fire(input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (fire) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tick(input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit got;
        int c1, c2, c3, n, rst_hold;

        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_hp", int'(car_hp), 3);
        cmp("rst_destroyed", int'(car_destroyed), 0);
        cmp("rst_fire", int'(fire), 0);
        cmp("rst_in_range", int'(in_range), 0);
        cmp("rst_tick", int'(frame_tick), 0);
        chk_on = 1'b1;
        @(posedge clk); #1 resetn = 1'b1;

        // Car far left of the zone: never shot.
        enable = 1'b1; car_active = 1'b1; car_x = 8'd0; car_y = 7'd60;
        n = 0;
        repeat (80) begin
            @(negedge clk);
            if (fire) n++;
        end
        cmp("far_fire_count", n, 0);
        cmp("far_hp", int'(car_hp), 3);

        // Car moves into the zone: in_range one cycle later, three shots.
        @(posedge clk); #1 car_x = 8'd40; car_y = 7'd20;
        @(negedge clk);
        cmp("range_lag_old", int'(in_range), 0);
        @(negedge clk);
        cmp("range_lag_new", int'(in_range), 1);
        wait_fire(40, got); cmp("fire1_seen", int'(got), 1); c1 = cyc;
        cmp("hp_at_fire1", int'(car_hp), 3);
        wait_fire(40, got); cmp("fire2_seen", int'(got), 1); c2 = cyc;
        cmp("hp_at_fire2", int'(car_hp), 2);
        wait_fire(40, got); cmp("fire3_seen", int'(got), 1); c3 = cyc;
        cmp("hp_at_fire3", int'(car_hp), 1);
        cmp("gap12", c2 - c1, 12);
        cmp("gap23", c3 - c2, 12);
        @(negedge clk);
        cmp("dead_flag", int'(car_destroyed), 1);
        cmp("dead_hp", int'(car_hp), 0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (fire) n++;
        end
        cmp("no_fourth_fire", n, 0);
        cmp("dead_held", int'(car_destroyed), 1);

        // Restart the car: hit points reload, first tick fires again.
        @(posedge clk); #1 car_reset = 1'b1;
        @(posedge clk); #1 car_reset = 1'b0;
        @(negedge clk);
        cmp("restart_hp", int'(car_hp), 3);
        cmp("restart_flag", int'(car_destroyed), 0);
        wait_fire(12, got); cmp("restart_fire", int'(got), 1);

        // car_reset coinciding with a frame tick while armed and in range.
        wait_tick(8, got); cmp("tick_found", int'(got), 1);
        @(posedge clk); #1 car_reset = 1'b1;
        @(posedge clk); #1 car_reset = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 car_reset = 1'b1;
        @(negedge clk);
        cmp("tick_with_reset", int'(frame_tick), 1);
        @(posedge clk); #1 car_reset = 1'b0;
        @(negedge clk);
        cmp("reset_beats_tick_fire", int'(fire), 0);
        cmp("reset_beats_tick_hp", int'(car_hp), 3);

        // Pause in mid-cooldown: no shots, hit points held.
        wait_fire(16, got); cmp("pre_pause_fire", int'(got), 1);
        wait_tick(8, got); cmp("pause_tick", int'(got), 1);
        @(posedge clk); #1 enable = 1'b0;
        n = 0;
        repeat (16) begin
            @(negedge clk);
            if (fire) n++;
        end
        cmp("pause_fire_count", n, 0);
        cmp("pause_hp", int'(car_hp), 2);
        @(posedge clk); #1 enable = 1'b1;

        // Asynchronous reset in cooldown with one hit point left.
        wait_fire(40, got); cmp("last_hp_fire", int'(got), 1);
        repeat (2) @(negedge clk);
        cmp("hp_one", int'(car_hp), 1);
        @(posedge clk); #1 resetn = 1'b0;
        #1;
        cmp("async_hp", int'(car_hp), 3);
        cmp("async_flag", int'(car_destroyed), 0);
        cmp("async_fire", int'(fire), 0);
        cmp("async_in_range", int'(in_range), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Randomised play around the zone boundary.
        car_x = 8'd80; car_y = 7'd20; rst_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) resetn = 1'b1;
            end else if ($urandom_range(0, 999) < 2) begin
                resetn = 1'b0; rst_hold = 2;
            end
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            if ($urandom_range(0, 99) < 3) car_active = ~car_active;
            car_reset = ($urandom_range(0, 99) < 1);
            if ($urandom_range(0, 99) < 2) begin
                car_x = 8'($urandom_range(20, 100));
                car_y = 7'($urandom_range(0, 80));
            end else begin
                car_x = car_x + 8'($urandom_range(0, 2)) - 8'd1;
                car_y = car_y + 7'($urandom_range(0, 2)) - 7'd1;
            end
        end
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tower_targeting.md
Name: tower_targeting

Overview:
- Consumer of the car's map position (top-left Counter_X/Counter_Y, 20x20 sprite).
- Decides when a fixed tower is in range and fires on 30 fps frame ticks.
- Tracks car hit points and raises the destroyed flag that drives the car controller's destroyed_state input.
- Sits beside the car datapath in the game top level; one instance per tower.

Parameters:
- TOWER_X, 60, tower centre x on 160x120 map
- TOWER_Y, 40, tower centre y on map
- RANGE, 30, half-width of square attack zone, map pixels
- COOLDOWN_FRAMES, 15, frames between shots (8-bit)
- CAR_HP, 5, hits to destroy car (4-bit)
- FRAME_CLKS, 1666666, clk cycles per frame (50 MHz / 30); shrink for simulation

Ports:
- clk  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  game running; low = pause
- car_reset  in  1  new wave/car restart; reloads HP
- car_active  in  1  car is on the path (past initial delay, not game over)
- car_x  in  8  car top-left x on map
- car_y  in  7  car top-left y on map
- in_range  out  1  registered range result
- fire  out  1  one-cycle shot pulse
- car_hp  out  4  remaining hit points
- car_destroyed  out  1  level; held until car_reset
- frame_tick  out  1  one-cycle pulse per frame

Behaviour:
- Reset, asynchronous on resetn low:
  - State = IDLE.
  - in_range=0, fire=0, car_hp=CAR_HP, car_destroyed=0, frame_tick=0.
  - Cooldown counter=0, frame counter=0.
- Frame counter:
  - Free-running 0..FRAME_CLKS-1; frame_tick=1 on the cycle the counter wraps.
  - Unaffected by enable and car_reset.
- Range check:
  - Centre: cx=car_x+10, cy=car_y+10, computed 9-bit unsigned.
  - in_range <= (|cx-TOWER_X| <= RANGE) && (|cy-TOWER_Y| <= RANGE); use 10-bit signed differences, no wrap.
  - Registered every cycle, so in_range lags position by 1 cycle.
- Priority, highest first: resetn > car_reset > enable low > state logic.
  - car_reset (sync, any state): state=IDLE, car_hp=CAR_HP, car_destroyed=0, cooldown=0, fire=0.
  - enable low: state=IDLE, fire=0; car_hp and cooldown preserved (pause, not restart).
- State machine:
  - IDLE: enable && car_active -> ARMED.
  - ARMED:
    - car_active low -> IDLE.
    - in_range && frame_tick -> FIRE.
  - FIRE (exactly one cycle):
    - fire=1, car_hp <= car_hp-1.
    - car_hp==1 -> DESTROYED.
    - Otherwise load cooldown=COOLDOWN_FRAMES and go to COOLDOWN.
  - COOLDOWN:
    - Decrement cooldown on each frame_tick.
    - Cooldown==0 with no tick -> ARMED; the next shot needs a later tick.
    - car_active low -> IDLE with cooldown preserved.
  - DESTROYED: car_destroyed=1, fire=0; leave only on car_reset or resetn.
- Boundaries:
  - car_hp never underflows; it saturates at 0 in DESTROYED.
  - CAR_HP=1: first FIRE goes straight to DESTROYED.
  - COOLDOWN_FRAMES=0: COOLDOWN exits to ARMED on the next cycle.
  - Car entering range mid-frame: shot occurs on the next frame_tick while in_range is still 1.
  - Car leaving range on the same cycle as frame_tick: the registered in_range value of that cycle decides.
  - car_reset and frame_tick together: car_reset wins, no fire.
- Latency: fire asserts 1 cycle after the frame_tick cycle that sees in_range=1 in ARMED.

Decomposition:
- Shared package game_pkg:
  - map dimensions 160x120
  - sprite size 20
  - FRAME_CLKS_30FPS = 1666666
  - state encoding localparams IDLE/ARMED/FIRE/COOLDOWN/DESTROYED (3-bit)
- Sub-module frame_tick_gen (counter plus pulse, param FRAME_CLKS); the car delay counter is intended to reuse it later.

Test Plan (FRAME_CLKS=4, COOLDOWN_FRAMES=2, CAR_HP=3, TOWER=(60,40), RANGE=30):
- resetn low mid-COOLDOWN with car_hp=1 -> outputs return immediately to car_hp=3, car_destroyed=0, fire=0, state IDLE.
- car at (0,60), active, enable=1 -> cx=10, |10-60|=50>30 -> in_range=0, no fire over 20 frames, car_hp=3.
- car at (40,20), cx=50, cy=30 -> in_range=1 one cycle later; fire pulses at frame ticks spaced 3 frames apart (fire, 2 cooldown ticks, next tick) -> car_hp 3,2,1,0, car_destroyed=1 after 3rd fire, no 4th fire.
- Destroyed, then car_reset pulse -> car_hp=3, car_destroyed=0, IDLE; next ARMED in range fires on the first frame_tick.
- enable low during COOLDOWN with cooldown=1 -> fire stays 0, car_hp holds 2, cooldown holds 1; re-enable -> IDLE, then ARMED.
- car_reset asserted on the same cycle as frame_tick in ARMED, in range -> fire=0, car_hp=3.
